// File: rtl/wb_byte_initiator.sv
// wb_byte_initiator: byte-stream command port issuing single-beat Wishbone classic reads/writes
module wb_byte_initiator #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic [7:0]  cmd_data,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   output logic [7:0]  rsp_data,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic        wbm_we_o,
   output logic [3:0]  wbm_sel_o,
   output logic [31:0] wbm_adr_o,
   output logic [31:0] wbm_dat_o,
   input  logic [31:0] wbm_dat_i,
   input  logic        wbm_ack_i,
   output logic        busy
);
   typedef enum logic [2:0] {OPC, ADDR, DATA, BUS, RESP} state_t;
   localparam logic [15:0] TLAST = 16'(TIMEOUT_CYCLES - 1);
   state_t      state;
   logic [1:0]  cnt;
   logic [2:0]  rsp_left;
   logic [15:0] tcnt;
   logic [31:0] rdat;
   logic        cmd_take;
   assign cmd_ready = (state == OPC) || (state == ADDR) || (state == DATA);
   assign busy      = state != OPC;
   assign cmd_take  = cmd_valid & cmd_ready;
   assign wbm_stb_o = wbm_cyc_o;
   assign wbm_sel_o = {4{wbm_cyc_o}};
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state     <= OPC;
         cnt       <= '0;
         rsp_left  <= '0;
         tcnt      <= '0;
         rdat      <= '0;
         rsp_data  <= '0;
         rsp_valid <= 1'b0;
         wbm_cyc_o <= 1'b0;
         wbm_we_o  <= 1'b0;
         wbm_adr_o <= '0;
         wbm_dat_o <= '0;
      end else begin
         unique case (state)
            OPC: if (cmd_take) begin
               cnt <= '0;
               if (cmd_data == 8'h57 || cmd_data == 8'h52) begin
                  wbm_we_o <= cmd_data == 8'h57;
                  state    <= ADDR;
               end else begin
                  rsp_data  <= 8'hEE;
                  rsp_valid <= 1'b1;
                  rsp_left  <= '0;
                  state     <= RESP;
               end
            end
            ADDR: if (cmd_take) begin
               wbm_adr_o <= {wbm_adr_o[23:0], cmd_data};
               cnt       <= cnt + 2'd1;
               if (cnt == 2'd3) begin
                  state     <= wbm_we_o ? DATA : BUS;
                  wbm_cyc_o <= !wbm_we_o;
                  tcnt      <= '0;
               end
            end
            DATA: if (cmd_take) begin
               wbm_dat_o <= {wbm_dat_o[23:0], cmd_data};
               cnt       <= cnt + 2'd1;
               if (cnt == 2'd3) begin
                  state     <= BUS;
                  wbm_cyc_o <= 1'b1;
                  tcnt      <= '0;
               end
            end
            BUS: begin
               // an ack arriving on the final timeout cycle still completes normally
               if (wbm_ack_i || tcnt == TLAST) begin
                  wbm_cyc_o <= 1'b0;
                  rdat      <= wbm_dat_i;
                  rsp_data  <= wbm_ack_i ? 8'h00 : 8'hFF;
                  rsp_valid <= 1'b1;
                  rsp_left  <= (wbm_ack_i && !wbm_we_o) ? 3'd4 : 3'd0;
                  state     <= RESP;
               end else begin
                  tcnt <= tcnt + 16'd1;
               end
            end
            RESP: if (rsp_ready) begin
               if (rsp_left == 3'd0) begin
                  rsp_valid <= 1'b0;
                  state     <= OPC;
               end else begin
                  rsp_data <= rdat[31:24];
                  rdat     <= {rdat[23:0], 8'h00};
                  rsp_left <= rsp_left - 3'd1;
               end
            end
            default: state <= OPC;
         endcase
      end
   end
endmodule
